axil_regbus_ctrl: RTL and testbench

//  AXI4-Lite slave front-end for the board-level control port. Terminates the

---
 rtl/axil_regbus_pkg.sv | 20 ++
 rtl/axil_skid_slot.sv | 39 +++
 rtl/axil_regbus_ctrl.sv | 169 ++++++++++++++++
 tb/tb_axil_regbus_ctrl.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regbus_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus controller.
package axil_regbus_pkg;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    RD_ACC,
    WR_RESP,
    RD_RESP
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/axil_skid_slot.sv
// One-entry holding register for an AXI channel. The entry is visible to the
// consumer in the same cycle it arrives, so a pop can bypass storage entirely.
module axil_skid_slot
  import axil_regbus_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         pop
);

  logic         full;
  logic [W-1:0] data_q;

  assign in_ready  = en & ~full;
  assign out_valid = full | (in_valid & in_ready);
  assign out_data  = full ? data_q : in_data;

  // A pop in the arrival cycle consumes the beat without ever storing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full   <= 1'b1;
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/axil_regbus_ctrl.sv
// AXI4-Lite slave that serialises reads and writes onto a simple register bus.
// Define REGBUS_TIMEOUT_EN to build the reg_ack watchdog (TIMEOUT_CYCLES).
module axil_regbus_ctrl
  import axil_regbus_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                control_aclk,
  input  logic                control_aresetn,
  input  logic [ADDR_W-1:0]   control_awaddr,
  input  logic                control_awvalid,
  output logic                control_awready,
  input  logic [DATA_W-1:0]   control_wdata,
  input  logic [DATA_W/8-1:0] control_wstrb,
  input  logic                control_wvalid,
  output logic                control_wready,
  output logic [1:0]          control_bresp,
  output logic                control_bvalid,
  input  logic                control_bready,
  input  logic [ADDR_W-1:0]   control_araddr,
  input  logic                control_arvalid,
  output logic                control_arready,
  output logic [DATA_W-1:0]   control_rdata,
  output logic [1:0]          control_rresp,
  output logic                control_rvalid,
  input  logic                control_rready,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic                reg_wr,
  output logic                reg_rd,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_ack,
  input  logic                reg_err
);

  localparam int STRB_W = DATA_W / 8;

  if (DATA_W != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("axil_regbus_ctrl: unsupported DATA_W or TIMEOUT_CYCLES");
  end

  logic                     bus_en;
  logic                     aw_valid, w_valid, ar_valid;
  logic [ADDR_W-1:0]        aw_addr, ar_addr;
  logic [STRB_W+DATA_W-1:0] w_bundle;
  logic [DATA_W-1:0]        w_data;
  logic [STRB_W-1:0]        w_strb;
  logic                     grant_wr, grant_rd, acc_end, timed_out;
  logic                     prio_wr;
  state_t                   state, state_next;

  // Keeps every ready low while in reset and for the first cycle after it.
  always_ff @(posedge control_aclk or negedge control_aresetn) begin
    if (!control_aresetn) bus_en <= 1'b0;
    else                  bus_en <= 1'b1;
  end

  axil_skid_slot #(.W(ADDR_W)) u_aw_slot (
    .clk(control_aclk), .rst_n(control_aresetn), .en(bus_en),
    .in_data(control_awaddr), .in_valid(control_awvalid), .in_ready(control_awready),
    .out_data(aw_addr), .out_valid(aw_valid), .pop(grant_wr)
  );

  axil_skid_slot #(.W(STRB_W + DATA_W)) u_w_slot (
    .clk(control_aclk), .rst_n(control_aresetn), .en(bus_en),
    .in_data({control_wstrb, control_wdata}), .in_valid(control_wvalid),
    .in_ready(control_wready),
    .out_data(w_bundle), .out_valid(w_valid), .pop(grant_wr)
  );

  axil_skid_slot #(.W(ADDR_W)) u_ar_slot (
    .clk(control_aclk), .rst_n(control_aresetn), .en(bus_en),
    .in_data(control_araddr), .in_valid(control_arvalid), .in_ready(control_arready),
    .out_data(ar_addr), .out_valid(ar_valid), .pop(grant_rd)
  );

  assign w_data = w_bundle[DATA_W-1:0];
  assign w_strb = w_bundle[STRB_W+DATA_W-1:DATA_W];

`ifdef REGBUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge control_aclk or negedge control_aresetn) begin
    if (!control_aresetn)                      tmo_cnt <= '0;
    else if (state == WR_ACC || state == RD_ACC) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else                                       tmo_cnt <= '0;
  end

  assign timed_out = (state == WR_ACC || state == RD_ACC) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  assign acc_end = reg_ack | reg_err | timed_out;

  always_ff @(posedge control_aclk or negedge control_aresetn) begin
    if (!control_aresetn) state <= IDLE;
    else                  state <= state_next;
  end

  // Misaligned grants skip the bus access and go straight to the response.
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (aw_valid && w_valid && (!ar_valid || prio_wr)) begin
          grant_wr   = 1'b1;
          state_next = is_misaligned(aw_addr[1:0]) ? WR_RESP : WR_ACC;
        end else if (ar_valid) begin
          grant_rd   = 1'b1;
          state_next = is_misaligned(ar_addr[1:0]) ? RD_RESP : RD_ACC;
        end
      end
      WR_ACC:  if (acc_end) state_next = WR_RESP;
      RD_ACC:  if (acc_end) state_next = RD_RESP;
      WR_RESP: if (control_bready) state_next = IDLE;
      RD_RESP: if (control_rready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign reg_wr         = (state == WR_ACC);
  assign reg_rd         = (state == RD_ACC);
  assign control_bvalid = (state == WR_RESP);
  assign control_rvalid = (state == RD_RESP);

  // Latch the granted request and the completion status; response fields only
  // change on grant or completion, so they stay stable while valid is pending.
  always_ff @(posedge control_aclk or negedge control_aresetn) begin
    if (!control_aresetn) begin
      prio_wr       <= 1'b1;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wstrb     <= '0;
      control_bresp <= RESP_OKAY;
      control_rresp <= RESP_OKAY;
      control_rdata <= '0;
    end else begin
      if (grant_wr) begin
        prio_wr       <= 1'b0;
        reg_addr      <= aw_addr;
        reg_wdata     <= w_data;
        reg_wstrb     <= w_strb;
        control_bresp <= is_misaligned(aw_addr[1:0]) ? RESP_SLVERR : RESP_OKAY;
      end
      if (grant_rd) begin
        prio_wr       <= 1'b1;
        reg_addr      <= ar_addr;
        control_rresp <= is_misaligned(ar_addr[1:0]) ? RESP_SLVERR : RESP_OKAY;
        control_rdata <= '0;
      end
      if (state == WR_ACC && acc_end) begin
        control_bresp <= (reg_err || !reg_ack) ? RESP_SLVERR : RESP_OKAY;
      end
      if (state == RD_ACC && acc_end) begin
        control_rresp <= (reg_err || !reg_ack) ? RESP_SLVERR : RESP_OKAY;
        control_rdata <= reg_err ? '0 : (reg_ack ? reg_rdata : DATA_W'(TIMEOUT_RDATA));
      end
    end
  end

endmodule

// File: tb/tb_axil_regbus_ctrl.sv
// Directed bench for axil_regbus_ctrl with a programmable register-bus responder.
// The watchdog scenario is only exercised when REGBUS_TIMEOUT_EN is defined.
module tb_axil_regbus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  control_awaddr = '0;
  logic        control_awvalid = 1'b0;
  logic        control_awready;
  logic [31:0] control_wdata = '0;
  logic [3:0]  control_wstrb = '0;
  logic        control_wvalid = 1'b0;
  logic        control_wready;
  logic [1:0]  control_bresp;
  logic        control_bvalid;
  logic        control_bready = 1'b0;
  logic [7:0]  control_araddr = '0;
  logic        control_arvalid = 1'b0;
  logic        control_arready;
  logic [31:0] control_rdata;
  logic [1:0]  control_rresp;
  logic        control_rvalid;
  logic        control_rready = 1'b0;
  logic [7:0]  reg_addr;
  logic        reg_wr, reg_rd;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata = 32'h0BAD_0BAD;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;

  int total = 0;
  int bad = 0;

  // Responder controls: ack after resp_delay strobe cycles; mode 0=ack, 1=err, 2=both.
  int          resp_delay = 0;
  int          resp_mode = 0;
  logic [31:0] resp_rdata = '0;
  int          strobe_age = 0;
  int          wr_cycles = 0;
  int          rd_cycles = 0;
  int          overlap = 0;
  int          log_n = 0;
  logic        log_is_wr [16];
  logic [7:0]  log_addr [16];
  logic [31:0] log_data [16];

  always #5 clk = ~clk;

  axil_regbus_ctrl dut (
    .control_aclk(clk), .control_aresetn(rst_n),
    .control_awaddr(control_awaddr), .control_awvalid(control_awvalid),
    .control_awready(control_awready),
    .control_wdata(control_wdata), .control_wstrb(control_wstrb),
    .control_wvalid(control_wvalid), .control_wready(control_wready),
    .control_bresp(control_bresp), .control_bvalid(control_bvalid),
    .control_bready(control_bready),
    .control_araddr(control_araddr), .control_arvalid(control_arvalid),
    .control_arready(control_arready),
    .control_rdata(control_rdata), .control_rresp(control_rresp),
    .control_rvalid(control_rvalid), .control_rready(control_rready),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .reg_err(reg_err)
  );

  // Register-bus responder and access log, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst_n || !(reg_wr || reg_rd)) begin
      strobe_age = 0;
      reg_ack = 1'b0;
      reg_err = 1'b0;
      reg_rdata = 32'h0BAD_0BAD;
    end else begin
      if (reg_wr) wr_cycles++;
      if (reg_rd) rd_cycles++;
      if (reg_wr && reg_rd) overlap++;
      if (strobe_age >= resp_delay) begin
        reg_ack = (resp_mode != 1);
        reg_err = (resp_mode != 0);
        reg_rdata = resp_rdata;
        if (log_n < 16) begin
          log_is_wr[log_n] = reg_wr;
          log_addr[log_n] = reg_addr;
          log_data[log_n] = reg_wr ? reg_wdata : resp_rdata;
          log_n++;
        end
      end else begin
        reg_ack = 1'b0;
        reg_err = 1'b0;
        reg_rdata = 32'h0BAD_0BAD;
      end
      strobe_age++;
    end
  end

  task automatic apply_reset;
    rst_n = 1'b0;
    control_awvalid = 1'b0;
    control_wvalid = 1'b0;
    control_arvalid = 1'b0;
    control_bready = 1'b0;
    control_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] a, output bit ok);
    control_awaddr = a;
    control_awvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = control_awready;
      @(posedge clk);
      #1;
    end
    control_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output bit ok);
    control_wdata = d;
    control_wstrb = s;
    control_wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = control_wready;
      @(posedge clk);
      #1;
    end
    control_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] a, output bit ok);
    control_araddr = a;
    control_arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = control_arready;
      @(posedge clk);
      #1;
    end
    control_arvalid = 1'b0;
  endtask

  task automatic wait_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = control_bvalid;
    end
  endtask

  task automatic wait_r(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = control_rvalid;
    end
  endtask

  task automatic pop_b;
    control_bready = 1'b1;
    @(posedge clk);
    #1 control_bready = 1'b0;
  endtask

  task automatic pop_r;
    control_rready = 1'b1;
    @(posedge clk);
    #1 control_rready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({control_awready, control_wready, control_arready} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b want 000",
               {control_awready, control_wready, control_arready});
    end
    total++;
    if ({control_bvalid, control_rvalid, reg_wr, reg_rd, control_bresp, control_rresp} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %h want 00",
               {control_bvalid, control_rvalid, reg_wr, reg_rd, control_bresp, control_rresp});
    end
    total++;
    if ({reg_addr, reg_wdata, reg_wstrb, control_rdata} !== 76'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h want 0", {reg_addr, reg_wdata, reg_wstrb, control_rdata});
    end
    apply_reset();
    @(negedge clk);
    total++;
    if ({control_awready, control_wready, control_arready} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL post_reset_ready: got %b want 111",
               {control_awready, control_wready, control_arready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_write;
    resp_delay = 0;
    resp_mode = 0;
    wr_cycles = 0;
    control_awaddr = 8'h10;
    control_awvalid = 1'b1;
    control_wdata = 32'h1234_5678;
    control_wstrb = 4'hF;
    control_wvalid = 1'b1;
    @(negedge clk);
    total++;
    if ({control_awready, control_wready} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL wr1_accept: got %b want 11", {control_awready, control_wready});
    end
    @(posedge clk);
    #1;
    control_awvalid = 1'b0;
    control_wvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({reg_wr, control_bvalid, reg_addr, reg_wdata, reg_wstrb} !== {2'b10, 8'h10, 32'h1234_5678, 4'hF}) begin
      bad++;
      $display("[TB] FAIL wr1_strobe: got %h want %h",
               {reg_wr, control_bvalid, reg_addr, reg_wdata, reg_wstrb},
               {2'b10, 8'h10, 32'h1234_5678, 4'hF});
    end
    @(negedge clk);
    total++;
    if ({reg_wr, control_bvalid, control_bresp} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL wr1_bvalid: got %b want 0100", {reg_wr, control_bvalid, control_bresp});
    end
    @(negedge clk);
    total++;
    if (control_bvalid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wr1_bhold: got %b want 1", control_bvalid);
    end
    pop_b();
    @(negedge clk);
    total++;
    if ({control_bvalid, wr_cycles} !== {1'b0, 32'd1}) begin
      bad++;
      $display("[TB] FAIL wr1_done: bvalid=%b wr_cycles=%0d want 0 and 1", control_bvalid, wr_cycles);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_w_before_aw;
    bit ok;
    log_n = 0;
    wr_cycles = 0;
    send_w(32'hA5A5_0F0F, 4'b1011, ok);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ok, wr_cycles} !== {1'b1, 32'd0}) begin
      bad++;
      $display("[TB] FAIL wfirst_wait: ok=%b wr_cycles=%0d want 1 and 0", ok, wr_cycles);
    end
    send_aw(8'h10, ok);
    wait_b(ok);
    total++;
    if ({ok, control_bresp} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL wfirst_bresp: got %b want 100", {ok, control_bresp});
    end
    pop_b();
    total++;
    if (wr_cycles !== 1 || log_n !== 1) begin
      bad++;
      $display("[TB] FAIL wfirst_count: wr_cycles=%0d log_n=%0d want 1 and 1", wr_cycles, log_n);
    end
    total++;
    if ({log_is_wr[0], log_addr[0], log_data[0], reg_wstrb} !== {1'b1, 8'h10, 32'hA5A5_0F0F, 4'b1011}) begin
      bad++;
      $display("[TB] FAIL wfirst_data: got %h want %h",
               {log_is_wr[0], log_addr[0], log_data[0], reg_wstrb},
               {1'b1, 8'h10, 32'hA5A5_0F0F, 4'b1011});
    end
  endtask

  task automatic test_read_hold;
    bit ok;
    resp_delay = 4;
    resp_rdata = 32'hCAFE_0001;
    rd_cycles = 0;
    send_ar(8'h20, ok);
    wait_r(ok);
    total++;
    if ({ok, rd_cycles} !== {1'b1, 32'd5}) begin
      bad++;
      $display("[TB] FAIL rd_wait: ok=%b rd_cycles=%0d want 1 and 5", ok, rd_cycles);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({control_rvalid, control_rresp, control_rdata} !== {1'b1, 2'b00, 32'hCAFE_0001}) begin
        bad++;
        $display("[TB] FAIL rd_hold%0d: got %h want %h", i,
                 {control_rvalid, control_rresp, control_rdata}, {1'b1, 2'b00, 32'hCAFE_0001});
      end
      @(negedge clk);
    end
    pop_r();
    @(negedge clk);
    total++;
    if (control_rvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rd_done: got %b want 0", control_rvalid);
    end
    resp_delay = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin;
    apply_reset();
    log_n = 0;
    overlap = 0;
    resp_delay = 0;
    resp_mode = 0;
    resp_rdata = 32'h2222_0000;
    control_bready = 1'b1;
    control_rready = 1'b1;
    control_awaddr = 8'h40;
    control_wdata = 32'h1111_0000;
    control_wstrb = 4'hF;
    control_araddr = 8'h44;
    control_awvalid = 1'b1;
    control_wvalid = 1'b1;
    control_arvalid = 1'b1;
    for (int i = 0; i < 100 && log_n < 4; i++) @(negedge clk);
    @(posedge clk);
    #1;
    control_awvalid = 1'b0;
    control_wvalid = 1'b0;
    control_arvalid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    control_bready = 1'b0;
    control_rready = 1'b0;
    total++;
    if (log_n < 4) begin
      bad++;
      $display("[TB] FAIL rr_count: got %0d want >=4", log_n);
    end else begin
      total++;
      if ({log_is_wr[0], log_is_wr[1], log_is_wr[2], log_is_wr[3]} !== 4'b1010) begin
        bad++;
        $display("[TB] FAIL rr_order: got %b want 1010",
                 {log_is_wr[0], log_is_wr[1], log_is_wr[2], log_is_wr[3]});
      end
      total++;
      if ({log_addr[0], log_addr[1]} !== 16'h4044) begin
        bad++;
        $display("[TB] FAIL rr_addr: got %h want 4044", {log_addr[0], log_addr[1]});
      end
    end
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("[TB] FAIL rr_overlap: got %0d want 0", overlap);
    end
  endtask

  task automatic test_slverr;
    bit ok;
    rd_cycles = 0;
    send_ar(8'h13, ok);
    wait_r(ok);
    total++;
    if ({ok, control_rresp, control_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      bad++;
      $display("[TB] FAIL mis_rd: got %h want %h", {ok, control_rresp, control_rdata}, {1'b1, 2'b10, 32'h0});
    end
    total++;
    if (rd_cycles !== 0) begin
      bad++;
      $display("[TB] FAIL mis_rd_strobe: got %0d want 0", rd_cycles);
    end
    pop_r();
    resp_mode = 1;
    send_w(32'h0000_BEEF, 4'hF, ok);
    send_aw(8'h18, ok);
    wait_b(ok);
    total++;
    if ({ok, control_bresp} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL err_wr: got %b want 110", {ok, control_bresp});
    end
    pop_b();
    resp_mode = 2;
    resp_rdata = 32'h55AA_55AA;
    send_ar(8'h24, ok);
    wait_r(ok);
    total++;
    if ({ok, control_rresp, control_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      bad++;
      $display("[TB] FAIL err_ack_rd: got %h want %h", {ok, control_rresp, control_rdata}, {1'b1, 2'b10, 32'h0});
    end
    pop_r();
    resp_mode = 0;
  endtask

  task automatic test_reset_mid_read;
    bit ok;
    bit seen;
    resp_delay = 50;
    send_ar(8'h28, ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = reg_rd;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_mid_strobe: got %b want 1", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({reg_rd, reg_wr, control_rvalid, control_bvalid, control_arready, reg_addr} !== 13'h0) begin
      bad++;
      $display("[TB] FAIL rst_mid_outputs: got %h want 0",
               {reg_rd, reg_wr, control_rvalid, control_bvalid, control_arready, reg_addr});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    resp_delay = 0;
    resp_rdata = 32'h0BEE_F123;
    send_ar(8'h2C, ok);
    wait_r(ok);
    total++;
    if ({ok, control_rresp, control_rdata} !== {1'b1, 2'b00, 32'h0BEE_F123}) begin
      bad++;
      $display("[TB] FAIL rst_next_rd: got %h want %h",
               {ok, control_rresp, control_rdata}, {1'b1, 2'b00, 32'h0BEE_F123});
    end
    pop_r();
  endtask

`ifdef REGBUS_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    resp_delay = 100000;
    rd_cycles = 0;
    send_ar(8'h30, ok);
    wait_r(ok);
    total++;
    if ({ok, control_rresp, control_rdata} !== {1'b1, 2'b10, 32'hDEAD_BEEF}) begin
      bad++;
      $display("[TB] FAIL tmo_rd: got %h want %h",
               {ok, control_rresp, control_rdata}, {1'b1, 2'b10, 32'hDEAD_BEEF});
    end
    total++;
    if (rd_cycles !== 255) begin
      bad++;
      $display("[TB] FAIL tmo_len: got %0d want 255", rd_cycles);
    end
    pop_r();
    resp_delay = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_read_hold();
    test_round_robin();
    test_slverr();
    test_reset_mid_read();
`ifdef REGBUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
